bp_peer: RTL and testbench
==========================

# bp_peer

Environment-side peer for one blocking input port and one blocking output port of a generated SCAM module. The transmit side buffers words from a local push interface and offers them on the module's blocking input (`*_sync` driven, `*_notify` observed). The receive side accepts words from the module's blocking output and buffers them for a local pop interface. It sits between test or host logic and a generated module, e.g. `b_in`/`b_out`-style ports.

## Interface
- `DEPTH`, 4 — entries per FIFO; power of two, ≥2
- `CNT_W`, 16 — width of the transfer counters

- `clk`  in  1  — clock, rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `push`  in  1  — enqueue `push_data` into TX FIFO
- `push_data`  in  32  — signed integer word
- `tx_full`  out  1  — TX FIFO holds `DEPTH` words
- `m_in`  out  32  — word offered to the module's blocking input; head of TX FIFO
- `m_in_sync`  out  1  — word available (TX not empty)
- `m_in_notify`  in  1  — module ready to read
- `m_out`  in  32  — word written by the module
- `m_out_notify`  in  1  — module is writing
- `m_out_sync`  out  1  — peer ready to accept (RX not full)
- `pop`  in  1  — dequeue RX head
- `pop_data`  out  32  — RX head; valid while `rx_empty`=0
- `rx_empty`  out  1  — RX FIFO empty
- `tx_count`, `rx_count`  out  CNT_W  — completed transfers, each direction
- `ovf`, `unf`  out  1  — sticky: push while full / pop while empty
- `rx_checksum`  out  32  — see Configuration

## Operation
- Transfer rule on either port: a word moves on a rising edge where `sync`=1 and `notify`=1. Either side may raise its signal first. No other cycle moves data.
- TX: `m_in_sync` = TX not empty. `m_in` = TX head. On an `m_in` transfer, pop the head and increment `tx_count`.
- RX: `m_out_sync` = RX not full. On an `m_out` transfer, write `m_out` at the tail and increment `rx_count`.
- `push` while `tx_full`=1: the word is dropped and `ovf` is set. `tx_full` is judged on pre-edge state, so a simultaneous TX transfer does not make room.
- `pop` while `rx_empty`=1: ignored, and `unf` is set.
- `push` with a TX transfer on a non-full, non-empty FIFO: both occur and occupancy is unchanged. `pop` with an RX transfer: both occur.
- The FIFO is written and read by pointer with wrap-around modulo `DEPTH`. Occupancy counter is `log2(DEPTH)+1` bits wide.
- Counters wrap modulo 2^CNT_W. Arithmetic is unsigned 32-bit; words pass through unmodified.
- Reset (any time, including mid-transfer): both FIFOs empty and pointers 0. `m_in_sync`=0, `m_out_sync`=1, `tx_full`=0, `rx_empty`=1, `m_in`=0, `pop_data`=0, counters=0, `ovf`=`unf`=0, `rx_checksum`=0. Buffered words are discarded.

## Timing
- All outputs derive from registered state only; there is no combinational path from any input to any output.
- Push to `m_in_sync`=1: 1 cycle (visible the cycle after the push edge).
- A word can leave every cycle when `m_in_notify` is held high: throughput is 1 word/cycle per direction.
- RX transfer to `rx_empty`=0 and `pop_data` valid: 1 cycle.
- `m_out_sync` falls in the cycle after the edge that fills RX, so no word is accepted into a full FIFO.
- Status flags and counters update on the same edge as the event that changes them.

## Configuration
- `BP_PEER_CHECKSUM_EN` defined: `rx_checksum` accumulates the 32-bit wrapping sum of every word accepted on `m_out`. It updates on the transfer edge and clears on reset.
- Not defined: `rx_checksum` is tied to 0 and the adder is not built.

## Test plan
- Reset release; push 5, 7, 9 with `m_in_notify`=1 → `m_in` shows 5, 7, 9 on consecutive cycles; `tx_count`=3; `m_in_sync` drops after the last word.
- Hold `m_in_notify`=0 and push 5 words with `DEPTH`=4 → `tx_full`=1 after 4 words; the 5th is dropped and `ovf`=1. Release `notify` → exactly 4 words drain, in order.
- Module writes 0xFFFFFFFF, then 1, with no pops → `m_out_sync` stays 1; after pops, `pop_data`=0xFFFFFFFF then 1; `rx_checksum`=0 when `BP_PEER_CHECKSUM_EN` is defined.
- Fill RX with 4 words, hold `m_out_notify`=1 → `m_out_sync`=0 and no 5th accept. One `pop` → exactly one further word accepted.
- Pop while empty → `unf`=1 and `rx_count` unchanged. Assert `rst`=0 mid-stream with 2 words in each FIFO → all outputs return to reset values asynchronously.
- Set `tx_count` near 0xFFFF via transfers, then 2 more transfers → `tx_count` wraps to 0x0001.

Source files
------------

// File: rtl/bp_peer_if.sv
// -----------------------------------------------------------------------------
// bp_peer_if
//
// Purpose: the blocking-port pair between bp_peer and a generated SCAM module.
// A word moves on a rising clock edge where the relevant sync and notify are
// both high.
//
// Signals:
//   m_in         word offered to the module's blocking input
//   m_in_sync    peer has a word available on m_in
//   m_in_notify  module is ready to read m_in
//   m_out        word written by the module's blocking output
//   m_out_notify module is writing m_out
//   m_out_sync   peer is ready to accept m_out
//
// Modports:
//   master  peer side (bp_peer)
//   slave   module side
// -----------------------------------------------------------------------------
interface bp_peer_if #(
    parameter int DATA_W = 32
);
    logic signed [DATA_W-1:0] m_in;
    logic                     m_in_sync;
    logic                     m_in_notify;
    logic signed [DATA_W-1:0] m_out;
    logic                     m_out_notify;
    logic                     m_out_sync;

    modport master (
        output m_in,
        output m_in_sync,
        input  m_in_notify,
        input  m_out,
        input  m_out_notify,
        output m_out_sync
    );

    modport slave (
        input  m_in,
        input  m_in_sync,
        output m_in_notify,
        output m_out,
        output m_out_notify,
        input  m_out_sync
    );
endinterface

// File: rtl/bp_peer.sv
// -----------------------------------------------------------------------------
// bp_peer
//
// Purpose: environment-side peer for one blocking input port and one blocking
// output port of a generated SCAM module. The transmit side buffers locally
// pushed words and offers them on the module's blocking input; the receive
// side accepts words from the module's blocking output and buffers them for
// a local pop interface.
//
// Optional feature: define BP_PEER_CHECKSUM_EN to build a 32-bit wrapping sum
// of every word accepted on m_out (rx_checksum). Undefined, rx_checksum is 0.
//
// Parameters:
//   DEPTH   entries per FIFO (power of two, >= 2)
//   CNT_W   width of the transfer counters
//   DATA_W  word width
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   push         enqueue push_data into the TX FIFO
//   push_data    word to enqueue
//   tx_full      TX FIFO holds DEPTH words
//   bus          blocking-port pair towards the module (master modport)
//   pop          dequeue the RX head
//   pop_data     RX head (0 while rx_empty)
//   rx_empty     RX FIFO empty
//   tx_count     completed transfers on m_in  (wraps)
//   rx_count     completed transfers on m_out (wraps)
//   ovf          sticky: push while full
//   unf          sticky: pop while empty
//   rx_checksum  wrapping sum of accepted m_out words (0 when not built)
//
// Every output is a function of registered state only.
// -----------------------------------------------------------------------------
module bp_peer #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic signed [DATA_W-1:0] push_data,
    output logic                     tx_full,
    bp_peer_if.master                bus,
    input  logic                     pop,
    output logic signed [DATA_W-1:0] pop_data,
    output logic                     rx_empty,
    output logic [CNT_W-1:0]         tx_count,
    output logic [CNT_W-1:0]         rx_count,
    output logic                     ovf,
    output logic                     unf,
    output logic [DATA_W-1:0]        rx_checksum
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] tx_mem [DEPTH];
    logic signed [DATA_W-1:0] rx_mem [DEPTH];

    logic [PTR_W-1:0] tx_wr_ptr;
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [OCC_W-1:0] tx_occ;
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W-1:0] rx_rd_ptr;
    logic [OCC_W-1:0] rx_occ;

    logic tx_empty;
    logic rx_full;

    // Event qualifiers, all judged on pre-edge state.
    logic tx_wr_en;
    logic tx_xfer;
    logic rx_xfer;
    logic rx_rd_en;

    assign tx_full  = (tx_occ == OCC_FULL);
    assign tx_empty = (tx_occ == '0);
    assign rx_full  = (rx_occ == OCC_FULL);
    assign rx_empty = (rx_occ == '0);

    // A full TX FIFO drops the push even if the head leaves on the same edge.
    assign tx_wr_en = push && !tx_full;
    assign tx_xfer  = !tx_empty && bus.m_in_notify;
    assign rx_xfer  = !rx_full && bus.m_out_notify;
    assign rx_rd_en = pop && !rx_empty;

    // ------------------------------------------------------------------
    // Port outputs
    // ------------------------------------------------------------------
    // Heads read as 0 while empty so reset values are well defined without
    // clearing the storage arrays.
    assign bus.m_in       = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign bus.m_in_sync  = !tx_empty;
    assign bus.m_out_sync = !rx_full;
    assign pop_data       = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (tx_wr_en) begin
            tx_mem[tx_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_occ    <= '0;
        end else begin
            if (tx_wr_en) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            end
            if (tx_xfer) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            end
            if (tx_wr_en && !tx_xfer) begin
                tx_occ <= tx_occ + OCC_W'(1);
            end else if (!tx_wr_en && tx_xfer) begin
                tx_occ <= tx_occ - OCC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rx_xfer) begin
            rx_mem[rx_wr_ptr] <= bus.m_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_occ    <= '0;
        end else begin
            if (rx_xfer) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_rd_en) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
            if (rx_xfer && !rx_rd_en) begin
                rx_occ <= rx_occ + OCC_W'(1);
            end else if (!rx_xfer && rx_rd_en) begin
                rx_occ <= rx_occ - OCC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count <= '0;
            rx_count <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            if (tx_xfer) begin
                tx_count <= tx_count + CNT_W'(1);
            end
            if (rx_xfer) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (push && tx_full) begin
                ovf <= 1'b1;
            end
            if (pop && rx_empty) begin
                unf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional receive checksum
    // ------------------------------------------------------------------
`ifdef BP_PEER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (rx_xfer) begin
            checksum <= checksum + $unsigned(bus.m_out);
        end
    end

    assign rx_checksum = checksum;
`else
    assign rx_checksum = '0;
`endif

endmodule

// File: tb/tb_bp_peer.sv
// -----------------------------------------------------------------------------
// tb_bp_peer
//
// Testbench for bp_peer. A driver applies one cycle of stimulus at a time and
// updates a queue-level model of both FIFOs; accepted words are pushed into
// expected-word queues that a separate monitor pops and compares whenever a
// word leaves on m_in or is popped from RX.
// -----------------------------------------------------------------------------
module tb_bp_peer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic signed [31:0] push_data;
    logic        tx_full;
    logic        pop;
    logic signed [31:0] pop_data;
    logic        rx_empty;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        ovf;
    logic        unf;
    logic [31:0] rx_checksum;

    always #5 clk = ~clk;

    bp_peer_if #(.DATA_W(32)) bus_if ();

    bp_peer #(.DEPTH(DEPTH), .CNT_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .tx_full    (tx_full),
        .bus        (bus_if.master),
        .pop        (pop),
        .pop_data   (pop_data),
        .rx_empty   (rx_empty),
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .ovf        (ovf),
        .unf        (unf),
        .rx_checksum(rx_checksum)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: words expected on m_in transfers / RX pops, in order.
    logic [31:0] tx_exp[$];
    logic [31:0] rx_exp[$];

    // Reference model state.
    int          tx_n;
    int          rx_n;
    int unsigned tx_cnt;
    int unsigned rx_cnt;
    bit          ovf_m;
    bit          unf_m;
    logic [31:0] sum_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        tx_exp.delete();
        rx_exp.delete();
        tx_n   = 0;
        rx_n   = 0;
        tx_cnt = 0;
        rx_cnt = 0;
        ovf_m  = 0;
        unf_m  = 0;
        sum_m  = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_full"},   {31'd0, tx_full}, 32'd0);
        chk({tag, "_m_in_sync"}, {31'd0, bus_if.m_in_sync}, 32'd0);
        chk({tag, "_m_out_sync"},{31'd0, bus_if.m_out_sync}, 32'd1);
        chk({tag, "_rx_empty"},  {31'd0, rx_empty}, 32'd1);
        chk({tag, "_m_in"},      bus_if.m_in, 32'd0);
        chk({tag, "_pop_data"},  pop_data, 32'd0);
        chk({tag, "_tx_count"},  {16'd0, tx_count}, 32'd0);
        chk({tag, "_rx_count"},  {16'd0, rx_count}, 32'd0);
        chk({tag, "_ovf"},       {31'd0, ovf}, 32'd0);
        chk({tag, "_unf"},       {31'd0, unf}, 32'd0);
        chk({tag, "_checksum"},  rx_checksum, 32'd0);
    endtask

    task automatic check_state();
        logic [31:0] sum_exp;
`ifdef BP_PEER_CHECKSUM_EN
        sum_exp = sum_m;
`else
        sum_exp = '0;
`endif
        chk("tx_full",    {31'd0, tx_full},           {31'd0, tx_n == DEPTH});
        chk("m_in_sync",  {31'd0, bus_if.m_in_sync},  {31'd0, tx_n > 0});
        chk("m_out_sync", {31'd0, bus_if.m_out_sync}, {31'd0, rx_n < DEPTH});
        chk("rx_empty",   {31'd0, rx_empty},          {31'd0, rx_n == 0});
        chk("tx_count",   {16'd0, tx_count},          tx_cnt % 32'h10000);
        chk("rx_count",   {16'd0, rx_count},          rx_cnt % 32'h10000);
        chk("ovf",        {31'd0, ovf},               {31'd0, ovf_m});
        chk("unf",        {31'd0, unf},               {31'd0, unf_m});
        chk("checksum",   rx_checksum,                sum_exp);
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input bit p, input logic [31:0] pd, input bit ni,
                        input bit no, input logic [31:0] od, input bit pp);
        bit tx_x;
        bit rx_x;
        push                = p;
        push_data           = pd;
        bus_if.m_in_notify  = ni;
        bus_if.m_out_notify = no;
        bus_if.m_out        = od;
        pop                 = pp;
        @(negedge clk);
        check_state();
        tx_x = (tx_n > 0) && ni;
        rx_x = (rx_n < DEPTH) && no;
        if (p) begin
            if (tx_n == DEPTH) ovf_m = 1;
            else begin
                tx_exp.push_back(pd);
                tx_n++;
            end
        end
        if (tx_x) begin
            tx_n--;
            tx_cnt++;
        end
        if (pp) begin
            if (rx_n == 0) unf_m = 1;
            else rx_n--;
        end
        if (rx_x) begin
            rx_exp.push_back(od);
            rx_n++;
            rx_cnt++;
            sum_m = sum_m + od;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares words as they leave the DUT.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus_if.m_in_sync === 1'b1 && bus_if.m_in_notify === 1'b1) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_word: got %0h with no word expected", bus_if.m_in);
                end else begin
                    chk("tx_word", bus_if.m_in, tx_exp.pop_front());
                end
            end
            if (pop === 1'b1 && rx_empty === 1'b0) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_word: got %0h with no word expected", pop_data);
                end else begin
                    chk("rx_word", pop_data, rx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        rst                 = 1'b0;
        push                = 1'b0;
        push_data           = '0;
        pop                 = 1'b0;
        bus_if.m_in_notify  = 1'b0;
        bus_if.m_out_notify = 1'b0;
        bus_if.m_out        = '0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        // Three words with notify held: one per cycle.
        step(1, 32'd5, 1, 0, 0, 0);
        step(1, 32'd7, 1, 0, 0, 0);
        step(1, 32'd9, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("tx3_count", {16'd0, tx_count}, 32'd3);

        // Overflow: five pushes into a stalled TX FIFO.
        for (int i = 0; i < 5; i++) step(1, 32'h100 + i, 0, 0, 0, 0);
        chk("ovf_full", {31'd0, tx_full}, 32'd1);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);
        chk("ovf_drained", {16'd0, tx_count}, 32'd7);

        // RX: two writes, then two pops.
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 0, 1, 32'd1, 0);
        chk("rx2_sync", {31'd0, bus_if.m_out_sync}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // RX full back-pressure with notify held.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 32'h200 + i, 0);
        chk("rxfull_sync", {31'd0, bus_if.m_out_sync}, 32'd0);
        step(0, 0, 0, 1, 32'h2FF, 1);
        step(0, 0, 0, 1, 32'h300, 0);
        step(0, 0, 0, 1, 32'h301, 0);
        chk("rxfull_one_more", {16'd0, rx_count}, 32'd7);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);

        // Underflow with the RX FIFO now empty.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("unf_flag", {31'd0, unf}, 32'd1);
        chk("unf_rx_count", {16'd0, rx_count}, 32'd7);

        // Asynchronous reset with two words in each FIFO.
        step(1, 32'hA1, 0, 1, 32'hB1, 0);
        step(1, 32'hA2, 0, 1, 32'hB2, 0);
        push                = 1'b0;
        bus_if.m_out_notify = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset("async_reset");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 1);

        // Counter wrap: 65537 transfers from zero leave tx_count at 1.
        push = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 65537; i++) step(1, i, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("tx_wrap", {16'd0, tx_count}, 32'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
